// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: holds the F-stage PC, selects the next PC and
// buffers a redirect that arrives while fetch is stalled.
module pc_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] HANDLER_PC  = ADDR_W'(32'h0000_4180),
  parameter logic [ADDR_W-1:0] ERET_OFFSET = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] IM_BASE     = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] IM_TOP      = ADDR_W'(32'h0000_6ffc)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redir_pending,
  output logic              f_adel
);

  logic [ADDR_W-1:0] pending_target;
  logic [ADDR_W-1:0] live_target;
  logic              redirect;

  assign redirect    = eret | br_take;
  assign live_target = eret ? (epc + ERET_OFFSET) : br_target;

  assign pc_plus4 = pc + ADDR_W'(4);
  assign f_adel   = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_TOP);

  // req outranks everything; a live redirect outranks a buffered one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_PC;
      redir_pending  <= 1'b0;
      pending_target <= '0;
    end else if (req) begin
      pc            <= HANDLER_PC;
      redir_pending <= 1'b0;
    end else if (stall) begin
      if (redirect) begin
        redir_pending  <= 1'b1;
        pending_target <= live_target;
      end
    end else if (redirect) begin
      pc            <= live_target;
      redir_pending <= 1'b0;
    end else if (redir_pending) begin
      pc            <= pending_target;
      redir_pending <= 1'b0;
    end else begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with fixed
// expectations, then random traffic compared against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        br_take;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redir_pending;
  logic        f_adel;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  longint unsigned m_pc;
  bit              m_pv;
  longint unsigned m_pt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .req           (req),
    .eret          (eret),
    .epc           (epc),
    .br_take       (br_take),
    .br_target     (br_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redir_pending (redir_pending),
    .f_adel        (f_adel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare at negedge.
  task automatic cyc(input bit rst_n, input bit st, input bit rq, input bit er,
                     input logic [31:0] ep, input bit bt, input logic [31:0] tg);
    longint unsigned target;
    reset = rst_n; stall = st; req = rq; eret = er; epc = ep;
    br_take = bt; br_target = tg;
    @(posedge clk);
    target = er ? (longint'(ep) + 0) % 64'h1_0000_0000 : longint'(tg);
    if (!rst_n) begin
      m_pc = 64'h3000; m_pv = 0; m_pt = 0;
    end else if (rq) begin
      m_pc = 64'h4180; m_pv = 0;
    end else if (st) begin
      if (er || bt) begin m_pv = 1; m_pt = target; end
    end else if (er || bt) begin
      m_pc = target; m_pv = 0;
    end else if (m_pv) begin
      m_pc = m_pt; m_pv = 0;
    end else begin
      m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end
    @(negedge clk);
    chk("pc", pc, 32'(m_pc));
    chk("pc_plus4", pc_plus4, 32'((m_pc + 4) % 64'h1_0000_0000));
    chk("redir_pending", {31'b0, redir_pending}, {31'b0, m_pv});
    chk("f_adel", {31'b0, f_adel},
        {31'b0, ((m_pc % 4) != 0) || (m_pc < 64'h3000) || (m_pc > 64'h6ffc)});
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic br(input logic [31:0] tg, input bit st);
    cyc(1, st, 0, 0, 32'h0, 1, tg);
  endtask

  initial begin
    m_pc = 0; m_pv = 0; m_pt = 0;
    reset = 0; stall = 0; req = 0; eret = 0; epc = 0; br_take = 0; br_target = 0;
    @(negedge clk);

    // reset and straight-line fetch
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 1, 1, 32'h1234, 1, 32'h5678);
    chk("reset pc", pc, 32'h3000);
    chk("reset pending", {31'b0, redir_pending}, 32'h0);
    chk("reset adel", {31'b0, f_adel}, 32'h0);
    idle(); chk("seq 3004", pc, 32'h3004);
    idle(); chk("seq 3008", pc, 32'h3008);
    idle(); chk("seq 300c", pc, 32'h300c);
    idle(); chk("seq 3010", pc, 32'h3010);

    // branch and eret redirect
    br(32'h3100, 0); chk("branch", pc, 32'h3100);
    idle();          chk("after branch", pc, 32'h3104);
    cyc(1, 0, 0, 1, 32'h3020, 1, 32'h3500); chk("eret beats br", pc, 32'h3020);

    // redirect buffered under stall
    br(32'h3200, 1); chk("stall hold", pc, 32'h3020);
    chk("pending set", {31'b0, redir_pending}, 32'h1);
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0); chk("stall hold 3", pc, 32'h3020);
    idle(); chk("pending taken", pc, 32'h3200);
    chk("pending clear", {31'b0, redir_pending}, 32'h0);
    br(32'h3200, 1);
    br(32'h3300, 1);
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(); chk("last wins", pc, 32'h3300);

    // exception priority
    br(32'h3200, 1);
    cyc(1, 1, 1, 0, 32'h0, 0, 32'h0); chk("req over stall", pc, 32'h4180);
    chk("req clears pending", {31'b0, redir_pending}, 32'h0);
    cyc(1, 0, 1, 1, 32'h3020, 1, 32'h3100); chk("req over redirects", pc, 32'h4180);

    // fetch address error
    br(32'h3002, 0); chk("adel misaligned", {31'b0, f_adel}, 32'h1);
    br(32'h7000, 0); chk("adel above", {31'b0, f_adel}, 32'h1);
    br(32'h6ffc, 0); chk("adel top ok", {31'b0, f_adel}, 32'h0);
    idle();          chk("adel 7000", {31'b0, f_adel}, 32'h1);
    br(32'h2ffc, 0); chk("adel below", {31'b0, f_adel}, 32'h1);

    // wrap-around
    br(32'hffff_fffc, 0); chk("wrap plus4", pc_plus4, 32'h0);
    idle(); chk("wrap pc", pc, 32'h0);
    chk("wrap adel", {31'b0, f_adel}, 32'h1);

    // reset mid-operation discards pending
    br(32'h3200, 1);
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h0); chk("mid reset pc", pc, 32'h3000);
    chk("mid reset pending", {31'b0, redir_pending}, 32'h0);
    idle(); chk("no stale redirect", pc, 32'h3004);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg, ep;
      tg = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 32'h3fff) & 32'h3ffc));
      ep = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 32'h3fff) & 32'h3ffc));
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) == 0),
          ep,
          ($urandom_range(0, 4) == 0),
          tg);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
